// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Types shared by the burst sequencer and the AHB manager it drives.
//   t_hsize     : AHB HSIZE encoding (bytes per beat = 2**hsize)
//   t_seq_state : burst sequencer control states
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } t_hsize;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } t_seq_state;

endpackage

// File: rtl/ahb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// ahb_burst_sequencer
// Turns one burst descriptor (address, beat count, size, wrap, direction)
// into a sequence of beat requests for an AHB manager, feeds write data
// through from a valid/ready stream and forwards read data back out.
//
// Ports
//   i_hclk, i_hreset_n          clock, async active-low reset
//   i_cmd_*  / o_cmd_ready      descriptor handshake
//   i_wdata, i_wvalid / o_wready write data stream
//   o_rdata, o_raddr, o_rvalid  read data stream (no backpressure)
//   o_done (pulse), o_err (sticky), i_clr_err
//   m_*                         manager-facing request / response signals
// ---------------------------------------------------------------------------
module ahb_burst_sequencer
  import ahb_pkg::*;
#(
  parameter int DATA_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  // descriptor
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [31:0]         i_cmd_addr,
  input  logic [15:0]         i_cmd_len,
  input  t_hsize              i_cmd_size,
  input  logic                i_cmd_wrap,
  // write stream
  input  logic [DATA_WDT-1:0] i_wdata,
  input  logic                i_wvalid,
  output logic                o_wready,
  // read stream
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [31:0]         o_raddr,
  output logic                o_rvalid,
  // status
  output logic                o_done,
  output logic                o_err,
  input  logic                i_clr_err,
  // manager requests
  output logic                m_idle,
  output logic                m_rd,
  output logic                m_wr,
  output logic                m_first_xfer,
  output logic                m_wrap,
  output logic [31:0]         m_addr,
  output logic [15:0]         m_min_len,
  output t_hsize              m_size,
  output logic [DATA_WDT-1:0] m_wr_data,
  // manager responses
  input  logic                m_stall,
  input  logic                m_err,
  input  logic [DATA_WDT-1:0] m_rd_data,
  input  logic [31:0]         m_rd_data_addr,
  input  logic                m_rd_data_dav
);

  t_seq_state  state;
  t_seq_state  next_state;

  // latched descriptor
  logic        desc_wr;
  logic [31:0] desc_addr;
  logic [15:0] desc_len;
  t_hsize      desc_size;
  logic        desc_wrap;

  // beats still to issue, read beats returned so far
  logic [15:0] remaining;
  logic [15:0] received;

  logic        cmd_accept;
  logic        offered;
  logic        beat_accept;
  logic        drain_complete;

  // A descriptor is only taken when no error is being reported, since an
  // error in the same cycle sends the block to ERR instead of RUN.
  assign cmd_accept  = (state == ST_IDLE) && i_cmd_valid && !m_err;
  assign offered     = (state == ST_RUN) && (remaining != 16'd0) &&
                       (!desc_wr || i_wvalid);
  assign beat_accept = offered && !m_stall;

  // Looks ahead at the beat arriving this cycle so DONE follows the last
  // returned read beat by exactly one cycle.
  assign drain_complete = (received == desc_len) ||
                          (m_rd_data_dav && ((received + 16'd1) == desc_len));

  // Beat attributes are stable for the whole burst; only the control
  // strobes below depend on the state.
  assign m_addr    = desc_addr;
  assign m_min_len = remaining;
  assign m_size    = desc_size;
  assign m_wr_data = i_wdata;

  // State register.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a manager error overrides every other transition.
  always_comb begin
    next_state = state;
    if (m_err) begin
      next_state = ST_ERR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_len == 16'd0) begin
              next_state = ST_DONE;
            end else begin
              next_state = ST_RUN;
            end
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (beat_accept && (remaining == 16'd1)) begin
            if (desc_wr) begin
              next_state = ST_DONE;
            end else begin
              next_state = ST_DRAIN;
            end
          end else begin
            next_state = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_complete) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_DRAIN;
          end
        end
        ST_DONE: begin
          next_state = ST_IDLE;
        end
        ST_ERR: begin
          if (i_clr_err) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_ERR;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Descriptor capture on acceptance.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      desc_wr   <= 1'b0;
      desc_addr <= 32'd0;
      desc_len  <= 16'd0;
      desc_size <= HSIZE_BYTE;
      desc_wrap <= 1'b0;
    end else if (cmd_accept) begin
      desc_wr   <= i_cmd_wr;
      desc_addr <= i_cmd_addr;
      desc_len  <= i_cmd_len;
      desc_size <= i_cmd_size;
      desc_wrap <= i_cmd_wrap;
    end
  end

  // Remaining-beat counter; the zero guard keeps it from wrapping.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      remaining <= 16'd0;
    end else if (cmd_accept) begin
      remaining <= i_cmd_len;
    end else if (beat_accept && (remaining != 16'd0)) begin
      remaining <= remaining - 16'd1;
    end
  end

  // Returned-read-beat counter, restarted with each new descriptor.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      received <= 16'd0;
    end else if (cmd_accept) begin
      received <= 16'd0;
    end else if (m_rd_data_dav) begin
      received <= received + 16'd1;
    end
  end

  // Read data path: one-cycle registered copy, forwarded in every state.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      o_rdata  <= '0;
      o_raddr  <= 32'd0;
      o_rvalid <= 1'b0;
    end else begin
      o_rdata  <= m_rd_data;
      o_raddr  <= m_rd_data_addr;
      o_rvalid <= m_rd_data_dav;
    end
  end

  // Control outputs decoded from the state register. In RUN with nothing
  // offered every strobe is low, which the manager turns into BUSY.
  always_comb begin
    o_cmd_ready  = 1'b0;
    o_wready     = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    m_idle       = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    m_first_xfer = 1'b0;
    m_wrap       = 1'b0;
    case (state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        m_idle      = 1'b1;
      end
      ST_RUN: begin
        m_rd         = offered && !desc_wr;
        m_wr         = offered && desc_wr;
        m_first_xfer = offered && (remaining == desc_len);
        m_wrap       = offered && desc_wrap;
        o_wready     = desc_wr && (remaining != 16'd0) && !m_stall;
      end
      ST_DRAIN: begin
        m_idle = 1'b1;
      end
      ST_DONE: begin
        o_done = 1'b1;
        m_idle = 1'b1;
      end
      ST_ERR: begin
        o_err  = 1'b1;
        m_idle = 1'b1;
      end
      default: begin
        m_idle = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ahb_burst_sequencer
// Directed sequence with randomized data, stalls and write-data gaps. The
// expected beat stream is derived from the descriptor alone: beat k of a
// burst of len beats is the first beat iff k == 0 and advertises len - k
// remaining; a model manager returns read data one cycle after each
// accepted read beat.
// ---------------------------------------------------------------------------
module tb_ahb_burst_sequencer;
  import ahb_pkg::*;

  localparam int DW = 32;

  logic          i_hclk = 1'b0;
  logic          i_hreset_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_wr;
  logic [31:0]   i_cmd_addr;
  logic [15:0]   i_cmd_len;
  t_hsize        i_cmd_size;
  logic          i_cmd_wrap;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid;
  logic          o_wready;
  logic [DW-1:0] o_rdata;
  logic [31:0]   o_raddr;
  logic          o_rvalid;
  logic          o_done;
  logic          o_err;
  logic          i_clr_err;
  logic          m_idle, m_rd, m_wr, m_first_xfer, m_wrap;
  logic [31:0]   m_addr;
  logic [15:0]   m_min_len;
  t_hsize        m_size;
  logic [DW-1:0] m_wr_data;
  logic          m_stall, m_err;
  logic [DW-1:0] m_rd_data;
  logic [31:0]   m_rd_data_addr;
  logic          m_rd_data_dav;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_burst_sequencer #(.DATA_WDT(DW)) dut (
    .i_hclk(i_hclk), .i_hreset_n(i_hreset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_cmd_size(i_cmd_size), .i_cmd_wrap(i_cmd_wrap),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_raddr(o_raddr), .o_rvalid(o_rvalid),
    .o_done(o_done), .o_err(o_err), .i_clr_err(i_clr_err),
    .m_idle(m_idle), .m_rd(m_rd), .m_wr(m_wr), .m_first_xfer(m_first_xfer),
    .m_wrap(m_wrap), .m_addr(m_addr), .m_min_len(m_min_len), .m_size(m_size),
    .m_wr_data(m_wr_data), .m_stall(m_stall), .m_err(m_err),
    .m_rd_data(m_rd_data), .m_rd_data_addr(m_rd_data_addr),
    .m_rd_data_dav(m_rd_data_dav)
  );

  always #5 i_hclk = ~i_hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_hclk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_cmd_valid    = 1'b0;
    i_cmd_wr       = 1'b0;
    i_cmd_addr     = 32'd0;
    i_cmd_len      = 16'd0;
    i_cmd_size     = HSIZE_BYTE;
    i_cmd_wrap     = 1'b0;
    i_wdata        = '0;
    i_wvalid       = 1'b0;
    i_clr_err      = 1'b0;
    m_stall        = 1'b0;
    m_err          = 1'b0;
    m_rd_data      = '0;
    m_rd_data_addr = 32'd0;
    m_rd_data_dav  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
    chk({tag, "_m_idle"},    m_idle,      1'b1);
    chk({tag, "_done"},      o_done,      1'b0);
    chk({tag, "_err"},       o_err,       1'b0);
    chk({tag, "_rvalid"},    o_rvalid,    1'b0);
    chk({tag, "_rdata"},     o_rdata,     32'd0);
    chk({tag, "_raddr"},     o_raddr,     32'd0);
    chk({tag, "_m_rdwr"},    {m_rd, m_wr, m_first_xfer, m_wrap}, 4'd0);
  endtask

  // Present one descriptor for a single cycle while the block is idle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                       input t_hsize size, input logic wrap);
    quiet_inputs();
    i_cmd_valid = 1'b1;
    i_cmd_wr    = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    i_cmd_size  = size;
    i_cmd_wrap  = wrap;
    @(negedge i_hclk);
    chk("issue_cmd_ready", o_cmd_ready, 1'b1);
    chk("issue_m_idle", m_idle, 1'b1);
    next_cycle();
    i_cmd_valid = 1'b0;
  endtask

  // stall_mode: 0 never, 1 random, 2 three cycles while beat index 3 is offered
  // wv_mode   : 0 always valid, 1 random gaps, 2 two-cycle gap after beat 0
  task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [15:0] len,
                           input t_hsize size, input logic wrap,
                           input int stall_mode, input int wv_mode);
    int            k = 0;
    int            cyc = 0;
    int            stall_cnt = 0;
    int            gap_cnt = 0;
    int            davs = 0;
    int            first_acc = -1;
    int            last_acc = -1;
    logic          prev_dav = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [31:0]   prev_daddr = 32'd0;
    logic          pend_dav = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_done_next;
    logic          finished = 1'b0;
    logic          was_stalled = 1'b0;
    logic [15:0]   held_len = 16'd0;
    logic          offer_exp;
    logic          accepted;

    issue(wr, addr, len, size, wrap);
    while (!finished && cyc < 300) begin
      case (stall_mode)
        1:       m_stall = ($urandom_range(0, 3) == 0);
        2:       m_stall = (k == 3) && (stall_cnt < 3);
        default: m_stall = 1'b0;
      endcase
      case (wv_mode)
        1:       i_wvalid = ($urandom_range(0, 2) != 0);
        2:       i_wvalid = !((k == 1) && (gap_cnt < 2));
        default: i_wvalid = 1'b1;
      endcase
      i_wdata        = $urandom;
      m_rd_data_dav  = pend_dav;
      m_rd_data      = pend_dav ? DW'($urandom) : '0;
      m_rd_data_addr = pend_dav ? $urandom : 32'd0;
      exp_done_next  = 1'b0;
      if (pend_dav) begin
        davs++;
        if (davs == int'(len)) exp_done_next = 1'b1;
      end

      @(negedge i_hclk);
      chk("rvalid", o_rvalid, prev_dav);
      if (prev_dav) begin
        chk("rdata", o_rdata, prev_data);
        chk("raddr", o_raddr, prev_daddr);
      end
      chk("done", o_done, exp_done);

      offer_exp = (k < int'(len)) && (!wr || i_wvalid);
      chk("m_rd", m_rd, offer_exp && !wr);
      chk("m_wr", m_wr, offer_exp && wr);
      if (offer_exp) begin
        chk("first_xfer", m_first_xfer, k == 0);
        chk("min_len", m_min_len, int'(len) - k);
        chk("m_addr", m_addr, addr);
        chk("m_size", m_size, size);
        chk("m_wrap", m_wrap, wrap);
        chk("m_idle_run", m_idle, 1'b0);
        if (wr) chk("wr_data", m_wr_data, i_wdata);
        if (was_stalled) chk("stall_hold_len", m_min_len, held_len);
      end else if (k < int'(len)) begin
        chk("busy_ctrl", {m_first_xfer, m_idle, m_wrap}, 3'd0);
      end
      if (wr) chk("wready", o_wready, (k < int'(len)) && !m_stall);

      accepted    = offer_exp && !m_stall;
      was_stalled = offer_exp && m_stall;
      held_len    = m_min_len;
      if (was_stalled) stall_cnt++;
      if (wr && (k == 1) && !i_wvalid) gap_cnt++;
      if (accepted) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        k++;
        if (wr && (k == int'(len))) exp_done_next = 1'b1;
      end
      if (exp_done) finished = 1'b1;
      prev_dav   = m_rd_data_dav;
      prev_data  = m_rd_data;
      prev_daddr = m_rd_data_addr;
      pend_dav   = accepted && !wr;
      exp_done   = exp_done_next;
      cyc++;
      next_cycle();
    end

    chk("beats_accepted", k, len);
    chk("burst_finished", finished, 1'b1);
    if (stall_mode == 0 && (!wr || wv_mode == 0))
      chk("beat_cycles", last_acc - first_acc, int'(len) - 1);
    if (stall_mode == 2) chk("stall_cycles", stall_cnt, 3);
    if (wv_mode == 2) chk("gap_cycles", gap_cnt, 2);

    quiet_inputs();
    @(negedge i_hclk);
    chk("post_cmd_ready", o_cmd_ready, 1'b1);
    chk("post_m_idle", m_idle, 1'b1);
    chk("post_done", o_done, 1'b0);
    next_cycle();
  endtask

  initial begin
    logic          rwr;
    logic [15:0]   rlen;
    logic [DW-1:0] err_data;

    quiet_inputs();
    i_hreset_n = 1'b0;
    @(negedge i_hclk);
    check_reset_values("reset");
    next_cycle();
    i_hreset_n = 1'b1;
    next_cycle();

    // read, 4 beats, no stall
    run_burst(1'b0, 32'h0000_0100, 16'd4, HSIZE_WORD, 1'b0, 0, 0);
    // write, 3 beats, write data gap after the first beat
    run_burst(1'b1, 32'h0000_2000, 16'd3, HSIZE_WORD, 1'b0, 0, 2);
    // read, 8 beats, 3-cycle stall mid-burst
    run_burst(1'b0, 32'h0000_3040, 16'd8, HSIZE_HALF, 1'b1, 2, 0);
    // single-beat write
    run_burst(1'b1, 32'h0000_4000, 16'd1, HSIZE_BYTE, 1'b0, 0, 0);

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      rwr  = 1'($urandom_range(0, 1));
      rlen = 16'($urandom_range(1, 10));
      run_burst(rwr, $urandom, rlen, t_hsize'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1, 1);
    end

    // zero-length descriptor
    issue(1'b1, 32'h0000_5000, 16'd0, HSIZE_WORD, 1'b0);
    i_wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_hclk);
      chk("len0_done", o_done, c == 0);
      chk("len0_rdwr", {m_rd, m_wr}, 2'd0);
      next_cycle();
    end
    quiet_inputs();

    // manager error during RUN
    issue(1'b0, 32'h0000_6000, 16'd6, HSIZE_WORD, 1'b0);
    next_cycle();
    m_err = 1'b1;
    next_cycle();
    m_err = 1'b0;
    err_data = DW'($urandom);
    m_rd_data = err_data;
    m_rd_data_dav = 1'b1;
    @(negedge i_hclk);
    chk("err_flag", o_err, 1'b1);
    chk("err_cmd_ready", o_cmd_ready, 1'b0);
    chk("err_wready", o_wready, 1'b0);
    chk("err_m_idle", m_idle, 1'b1);
    chk("err_m_rd", m_rd, 1'b0);
    next_cycle();
    m_rd_data_dav = 1'b0;
    m_err = 1'b1;
    i_clr_err = 1'b1;
    @(negedge i_hclk);
    chk("err_fwd_rvalid", o_rvalid, 1'b1);
    chk("err_fwd_rdata", o_rdata, err_data);
    next_cycle();
    m_err = 1'b0;
    @(negedge i_hclk);
    chk("err_wins_over_clr", o_err, 1'b1);
    next_cycle();
    i_clr_err = 1'b0;
    @(negedge i_hclk);
    chk("err_cleared", o_err, 1'b0);
    chk("err_clr_cmd_ready", o_cmd_ready, 1'b1);
    next_cycle();

    // reset at beat 2 of a 5-beat write
    issue(1'b1, 32'h0000_7000, 16'd5, HSIZE_WORD, 1'b0);
    i_wvalid = 1'b1;
    m_rd_data = 32'hA5A5_0001;
    m_rd_data_addr = 32'h0000_7777;
    m_rd_data_dav = 1'b1;
    @(negedge i_hclk);
    chk("rst_beat1_first", m_first_xfer, 1'b1);
    next_cycle();
    @(negedge i_hclk);
    chk("rst_beat2_wr", m_wr, 1'b1);
    chk("rst_beat2_len", m_min_len, 16'd4);
    #1;
    i_hreset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    next_cycle();
    quiet_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge i_hclk);
      check_reset_values("rst_hold");
      next_cycle();
    end
    i_hreset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_hclk);
      chk("rst_no_done", o_done, 1'b0);
      chk("rst_idle_ready", o_cmd_ready, 1'b1);
      next_cycle();
    end
    run_burst(1'b0, 32'h0000_8000, 16'd5, HSIZE_WORD, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
